// File: rtl/pwm_regif_if.sv
// APB-style bus bundle between a bus master and the pwm_regif register slave.
interface pwm_regif_if #(
    parameter int unsigned ADDR_W = 6
);
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [ADDR_W-1:0] paddr;
    logic [31:0]       pwdata;
    logic [31:0]       prdata;
    logic              pready;
    logic              pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/pwm_regif.sv
// APB-style register slave feeding the 4-channel PWM block.
// Shadow FREQ/DUTY registers are copied to the active outputs by a CTRL commit,
// so all channels change on the same cycle. Optional write lock is enabled by
// defining PWM_REGIF_LOCK_EN (adds the LOCK register at 0x28).
module pwm_regif #(
    parameter int unsigned ADDR_W   = 6,
    parameter logic [15:0] RST_FREQ = 16'd1000,
    parameter logic [6:0]  DUTY_MAX = 7'd100
) (
    input  logic        mclk,
    input  logic        reset,
    pwm_regif_if.slave  apb,
    output logic [15:0] pwm_freq1,
    output logic [15:0] pwm_freq2,
    output logic [15:0] pwm_freq3,
    output logic [15:0] pwm_freq4,
    output logic [6:0]  pwm_duty1,
    output logic [6:0]  pwm_duty2,
    output logic [6:0]  pwm_duty3,
    output logic [6:0]  pwm_duty4
);
    localparam int unsigned WW = ADDR_W - 2;

    typedef enum logic [1:0] {StIdle, StSetup, StAccess, StRwait} state_e;

    state_e       state_q;
    logic [31:0]  prdata_q;
    logic [15:0]  freq_sh_q  [4];
    logic [15:0]  freq_act_q [4];
    logic [6:0]   duty_sh_q  [4];
    logic [6:0]   duty_act_q [4];
    logic [3:0]   en_q;
    logic         pending_q;
    logic         commit_q;
`ifdef PWM_REGIF_LOCK_EN
    logic         lock_q;
`endif

    logic [WW-1:0] widx;
    logic [1:0]    ch;
    logic          is_freq, is_duty, is_ctrl, is_status, is_lock;
    logic          wr_err, rd_err;
    logic [31:0]   rdata;
    logic          wr_acc, rd_acc, rwait_acc, wr_ok;
    logic [6:0]    duty_clamped;

    assign widx = apb.paddr[ADDR_W-1:2];
    assign ch   = widx[1:0];

    // Address decode, write-error rules and read mux.
    always_comb begin
        is_freq   = (widx[WW-1:2] == '0);
        is_duty   = (widx[WW-1:2] == (WW-2)'(1));
        is_ctrl   = (widx == WW'(8));
        is_status = (widx == WW'(9));
        is_lock   = (widx == WW'(10));

        wr_err = 1'b0;
        if (is_freq) begin
            wr_err = (apb.pwdata[15:0] == 16'd0);
        end else if (is_duty || is_ctrl) begin
            wr_err = 1'b0;
        end else if (is_lock) begin
`ifdef PWM_REGIF_LOCK_EN
            wr_err = !((apb.pwdata == 32'h5A5A_0001) || (apb.pwdata == 32'h5A5A_0000));
`else
            wr_err = 1'b1;
`endif
        end else begin
            wr_err = 1'b1;
        end
`ifdef PWM_REGIF_LOCK_EN
        if (lock_q && (is_freq || is_duty || is_ctrl)) begin
            wr_err = 1'b1;
        end
`endif

        rdata  = '0;
        rd_err = 1'b0;
        if (is_freq) begin
            rdata[15:0] = freq_sh_q[ch];
        end else if (is_duty) begin
            rdata[6:0] = duty_sh_q[ch];
        end else if (is_ctrl) begin
            rdata[4:1] = en_q;
        end else if (is_status) begin
            rdata[0] = pending_q;
        end else if (is_lock) begin
`ifdef PWM_REGIF_LOCK_EN
            rdata[0] = lock_q;
`else
            rd_err = 1'b1;
`endif
        end else begin
            rd_err = 1'b1;
        end

        duty_clamped = (apb.pwdata[6:0] > DUTY_MAX) ? DUTY_MAX : apb.pwdata[6:0];
    end

    // Final-cycle strobes; pready/pslverr stay low unless psel and penable are held.
    assign wr_acc    = (state_q == StAccess) && apb.psel && apb.penable && apb.pwrite;
    assign rd_acc    = (state_q == StAccess) && apb.psel && apb.penable && !apb.pwrite;
    assign rwait_acc = (state_q == StRwait) && apb.psel && apb.penable;
    assign wr_ok     = wr_acc && !wr_err;

    assign apb.pready  = wr_acc || rwait_acc;
    assign apb.pslverr = (wr_acc && wr_err) || (rwait_acc && rd_err);
    assign apb.prdata  = prdata_q;

    // Bus FSM with registered read data; read data is captured on the ACCESS edge.
    always_ff @(posedge mclk or negedge reset) begin
        if (!reset) begin
            state_q  <= StIdle;
            prdata_q <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (apb.psel && !apb.penable) state_q <= StSetup;
                end
                StSetup: begin
                    if (!apb.psel) state_q <= StIdle;
                    else if (apb.penable) state_q <= StAccess;
                end
                StAccess: begin
                    if (!apb.psel) begin
                        state_q <= StIdle;
                    end else if (!apb.penable) begin
                        state_q <= StSetup;
                    end else if (apb.pwrite) begin
                        state_q <= StIdle;
                    end else begin
                        prdata_q <= rd_err ? 32'd0 : rdata;
                        state_q  <= StRwait;
                    end
                end
                StRwait: begin
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Register file: shadow writes, enables, commit copy and pending flag.
    always_ff @(posedge mclk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 4; i++) begin
                freq_sh_q[i]  <= RST_FREQ;
                freq_act_q[i] <= RST_FREQ;
                duty_sh_q[i]  <= '0;
                duty_act_q[i] <= '0;
            end
            en_q      <= '0;
            pending_q <= 1'b0;
            commit_q  <= 1'b0;
`ifdef PWM_REGIF_LOCK_EN
            lock_q    <= 1'b0;
`endif
        end else begin
            // Copy sees pre-write shadows; a same-edge shadow write re-sets pending.
            if (commit_q) begin
                for (int i = 0; i < 4; i++) begin
                    freq_act_q[i] <= freq_sh_q[i];
                    duty_act_q[i] <= duty_sh_q[i];
                end
                pending_q <= 1'b0;
            end
            commit_q <= 1'b0;
            if (wr_ok) begin
                if (is_freq) begin
                    freq_sh_q[ch] <= apb.pwdata[15:0];
                    pending_q     <= 1'b1;
                end
                if (is_duty) begin
                    duty_sh_q[ch] <= duty_clamped;
                    pending_q     <= 1'b1;
                end
                if (is_ctrl) begin
                    en_q <= apb.pwdata[4:1];
                    if (apb.pwdata[0]) commit_q <= 1'b1;
                end
`ifdef PWM_REGIF_LOCK_EN
                if (is_lock) lock_q <= apb.pwdata[0];
`endif
            end
        end
    end

    assign pwm_freq1 = freq_act_q[0];
    assign pwm_freq2 = freq_act_q[1];
    assign pwm_freq3 = freq_act_q[2];
    assign pwm_freq4 = freq_act_q[3];
    assign pwm_duty1 = en_q[0] ? duty_act_q[0] : 7'd0;
    assign pwm_duty2 = en_q[1] ? duty_act_q[1] : 7'd0;
    assign pwm_duty3 = en_q[2] ? duty_act_q[2] : 7'd0;
    assign pwm_duty4 = en_q[3] ? duty_act_q[3] : 7'd0;
endmodule

// File: tb/tb_pwm_regif.sv
// Self-checking bench for pwm_regif: table of bus transfers with a scoreboard,
// plus hand-written sequences for commit timing, RWAIT abort and reset abort.
module tb_pwm_regif;
    logic mclk = 1'b0;
    logic reset = 1'b0;
    logic [15:0] pwm_freq1, pwm_freq2, pwm_freq3, pwm_freq4;
    logic [6:0]  pwm_duty1, pwm_duty2, pwm_duty3, pwm_duty4;

    int n_checks = 0;
    int n_errors = 0;

    pwm_regif_if #(.ADDR_W(6)) apb ();

    pwm_regif #(
        .ADDR_W   (6),
        .RST_FREQ (16'd1000),
        .DUTY_MAX (7'd100)
    ) dut (
        .mclk      (mclk),
        .reset     (reset),
        .apb       (apb),
        .pwm_freq1 (pwm_freq1),
        .pwm_freq2 (pwm_freq2),
        .pwm_freq3 (pwm_freq3),
        .pwm_freq4 (pwm_freq4),
        .pwm_duty1 (pwm_duty1),
        .pwm_duty2 (pwm_duty2),
        .pwm_duty3 (pwm_duty3),
        .pwm_duty4 (pwm_duty4)
    );

    always #5 mclk = ~mclk;

    typedef struct {
        string       name;
        logic        wr;
        logic [5:0]  addr;
        logic [31:0] data;
        logic        exp_err;
        logic [31:0] exp_rd;
    } vec_t;

    typedef struct {
        string       name;
        logic        wr;
        logic        err;
        logic [31:0] rd;
    } exp_t;

    exp_t sb_q[$];
    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One full transfer: setup, access, wait for pready (bounded), compare, release.
    task automatic xfer(input string name, input logic wr, input logic [5:0] addr,
                        input logic [31:0] data, input logic exp_err,
                        input logic [31:0] exp_rd);
        exp_t e;
        int   cnt;
        bit   got;
        @(posedge mclk); #1;
        apb.psel    = 1'b1;
        apb.penable = 1'b0;
        apb.pwrite  = wr;
        apb.paddr   = addr;
        apb.pwdata  = data;
        sb_q.push_back('{name: name, wr: wr, err: exp_err, rd: exp_rd});
        @(posedge mclk); #1;
        apb.penable = 1'b1;
        cnt = 0;
        got = 1'b0;
        while (!got && cnt < 8) begin
            @(negedge mclk);
            if (apb.pready) got = 1'b1;
            else cnt++;
        end
        e = sb_q.pop_front();
        if (!got) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s timeout: got no pready expected pready", e.name);
        end else begin
            chk({e.name, " latency"}, cnt, e.wr ? 32'd1 : 32'd2);
            chk({e.name, " pslverr"}, {31'd0, apb.pslverr}, {31'd0, e.err});
            if (!e.wr) chk({e.name, " prdata"}, apb.prdata, e.rd);
        end
        @(posedge mclk); #1;
        apb.psel    = 1'b0;
        apb.penable = 1'b0;
    endtask

    initial begin
        apb.psel    = 1'b0;
        apb.penable = 1'b0;
        apb.pwrite  = 1'b0;
        apb.paddr   = '0;
        apb.pwdata  = '0;

        // Register-level vectors applied from reset state.
        vecs.push_back('{"rd STATUS rst", 1'b0, 6'h24, 32'h0, 1'b0, 32'h0});
        vecs.push_back('{"rd FREQ3 rst",  1'b0, 6'h08, 32'h0, 1'b0, 32'h3E8});
        vecs.push_back('{"rd DUTY2 rst",  1'b0, 6'h14, 32'h0, 1'b0, 32'h0});
        vecs.push_back('{"rd unmapped",   1'b0, 6'h30, 32'h0, 1'b1, 32'h0});
        vecs.push_back('{"wr unmapped",   1'b1, 6'h2C, 32'h1, 1'b1, 32'h0});
        vecs.push_back('{"wr STATUS",     1'b1, 6'h24, 32'h1, 1'b1, 32'h0});
        vecs.push_back('{"rd STATUS clr", 1'b0, 6'h24, 32'h0, 1'b0, 32'h0});
        vecs.push_back('{"wr FREQ2=0",    1'b1, 6'h04, 32'h0, 1'b1, 32'h0});
        vecs.push_back('{"rd FREQ2 kept", 1'b0, 6'h04, 32'h0, 1'b0, 32'h3E8});
        vecs.push_back('{"wr DUTY2=7F",   1'b1, 6'h14, 32'h7F, 1'b0, 32'h0});
        vecs.push_back('{"rd DUTY2 clmp", 1'b0, 6'h14, 32'h0, 1'b0, 32'h64});
        vecs.push_back('{"wr DUTY3 hi",   1'b1, 6'h18, 32'hFFFFFF32, 1'b0, 32'h0});
        vecs.push_back('{"rd DUTY3",      1'b0, 6'h18, 32'h0, 1'b0, 32'h32});
        vecs.push_back('{"rd STATUS pnd", 1'b0, 6'h24, 32'h0, 1'b0, 32'h1});
        vecs.push_back('{"wr FREQ4",      1'b1, 6'h0C, 32'h12345678, 1'b0, 32'h0});
        vecs.push_back('{"rd FREQ4",      1'b0, 6'h0C, 32'h0, 1'b0, 32'h5678});
        vecs.push_back('{"wr CTRL EN2",   1'b1, 6'h20, 32'h04, 1'b0, 32'h0});
        vecs.push_back('{"rd CTRL",       1'b0, 6'h20, 32'h0, 1'b0, 32'h04});

        repeat (2) @(posedge mclk);
        #1;
        chk("rst pready", {31'd0, apb.pready}, 32'd0);
        chk("rst prdata", apb.prdata, 32'd0);
        @(negedge mclk);
        reset = 1'b1;
        @(posedge mclk); #1;
        chk("rst freq1", {16'd0, pwm_freq1}, 32'd1000);
        chk("rst freq4", {16'd0, pwm_freq4}, 32'd1000);
        chk("rst duty1", {25'd0, pwm_duty1}, 32'd0);
        chk("rst duty3", {25'd0, pwm_duty3}, 32'd0);

        for (int i = 0; i < vecs.size(); i++) begin
            xfer(vecs[i].name, vecs[i].wr, vecs[i].addr, vecs[i].data,
                 vecs[i].exp_err, vecs[i].exp_rd);
        end
        // EN2 set but nothing committed yet: active duty2 still 0.
        chk("duty2 pre-commit", {25'd0, pwm_duty2}, 32'd0);

        // Commit timing: outputs move one cycle after the CTRL access edge.
        xfer("wr FREQ1=500", 1'b1, 6'h00, 32'd500, 1'b0, 32'h0);
        xfer("wr DUTY1=40",  1'b1, 6'h10, 32'd40, 1'b0, 32'h0);
        xfer("wr CTRL 03",   1'b1, 6'h20, 32'h03, 1'b0, 32'h0);
        chk("freq1 at ctrl edge", {16'd0, pwm_freq1}, 32'd1000);
        @(posedge mclk); #1;
        chk("freq1 committed", {16'd0, pwm_freq1}, 32'd500);
        chk("duty1 committed", {25'd0, pwm_duty1}, 32'd40);
        chk("freq4 committed", {16'd0, pwm_freq4}, 32'h5678);
        chk("duty2 disabled",  {25'd0, pwm_duty2}, 32'd0);
        xfer("rd STATUS post", 1'b0, 6'h24, 32'h0, 1'b0, 32'h0);
        xfer("wr CTRL 06", 1'b1, 6'h20, 32'h06, 1'b0, 32'h0);
        chk("duty2 enabled", {25'd0, pwm_duty2}, 32'd100);
        chk("duty1 still",   {25'd0, pwm_duty1}, 32'd40);

        // Commit followed by DUTY4 write; EN4 off masks the active value.
        xfer("wr CTRL 07",   1'b1, 6'h20, 32'h07, 1'b0, 32'h0);
        xfer("wr DUTY4=20",  1'b1, 6'h1C, 32'd20, 1'b0, 32'h0);
        xfer("rd STATUS d4", 1'b0, 6'h24, 32'h0, 1'b0, 32'h1);
        xfer("wr CTRL 07b",  1'b1, 6'h20, 32'h07, 1'b0, 32'h0);
        @(posedge mclk); #1;
        chk("duty4 masked", {25'd0, pwm_duty4}, 32'd0);
        xfer("rd STATUS c2", 1'b0, 6'h24, 32'h0, 1'b0, 32'h0);
        xfer("wr CTRL 16",   1'b1, 6'h20, 32'h16, 1'b0, 32'h0);
        chk("duty4 enabled", {25'd0, pwm_duty4}, 32'd20);
        chk("duty3 off",     {25'd0, pwm_duty3}, 32'd0);

`ifdef PWM_REGIF_LOCK_EN
        xfer("wr LOCK on",   1'b1, 6'h28, 32'h5A5A0001, 1'b0, 32'h0);
        xfer("rd LOCK",      1'b0, 6'h28, 32'h0, 1'b0, 32'h1);
        xfer("wr FREQ1 lkd", 1'b1, 6'h00, 32'd200, 1'b1, 32'h0);
        xfer("wr CTRL lkd",  1'b1, 6'h20, 32'h17, 1'b1, 32'h0);
        @(posedge mclk); #1;
        chk("freq1 locked",  {16'd0, pwm_freq1}, 32'd500);
        xfer("rd FREQ1 lkd", 1'b0, 6'h00, 32'h0, 1'b0, 32'd500);
        xfer("wr LOCK bad",  1'b1, 6'h28, 32'h12345678, 1'b1, 32'h0);
        xfer("wr LOCK off",  1'b1, 6'h28, 32'h5A5A0000, 1'b0, 32'h0);
        xfer("wr FREQ1 ok",  1'b1, 6'h00, 32'd200, 1'b0, 32'h0);
        xfer("wr CTRL 17",   1'b1, 6'h20, 32'h17, 1'b0, 32'h0);
        @(posedge mclk); #1;
        chk("freq1 unlocked", {16'd0, pwm_freq1}, 32'd200);
`else
        xfer("wr LOCK unmap", 1'b1, 6'h28, 32'h5A5A0001, 1'b1, 32'h0);
        xfer("rd LOCK unmap", 1'b0, 6'h28, 32'h0, 1'b1, 32'h0);
`endif

        // psel dropped in RWAIT: no pready, FSM returns to IDLE.
        @(posedge mclk); #1;
        apb.psel    = 1'b1;
        apb.penable = 1'b0;
        apb.pwrite  = 1'b0;
        apb.paddr   = 6'h08;
        @(posedge mclk); #1;
        apb.penable = 1'b1;
        repeat (2) @(posedge mclk);
        #1;
        apb.psel    = 1'b0;
        apb.penable = 1'b0;
        @(negedge mclk);
        chk("rwait drop pready", {31'd0, apb.pready}, 32'd0);
        @(negedge mclk);
        chk("idle pready", {31'd0, apb.pready}, 32'd0);
        xfer("rd FREQ3 after", 1'b0, 6'h08, 32'h0, 1'b0, 32'h3E8);

        // Reset mid-write: outputs go to reset values at once, write is lost.
        @(posedge mclk); #1;
        apb.psel    = 1'b1;
        apb.penable = 1'b0;
        apb.pwrite  = 1'b1;
        apb.paddr   = 6'h00;
        apb.pwdata  = 32'd300;
        @(posedge mclk); #1;
        apb.penable = 1'b1;
        @(negedge mclk);
        #2;
        reset = 1'b0;
        #1;
        chk("arst freq1",  {16'd0, pwm_freq1}, 32'd1000);
        chk("arst freq4",  {16'd0, pwm_freq4}, 32'd1000);
        chk("arst duty1",  {25'd0, pwm_duty1}, 32'd0);
        chk("arst duty2",  {25'd0, pwm_duty2}, 32'd0);
        chk("arst pready", {31'd0, apb.pready}, 32'd0);
        apb.psel    = 1'b0;
        apb.penable = 1'b0;
        @(negedge mclk);
        reset = 1'b1;
        xfer("rd FREQ1 rst2",  1'b0, 6'h00, 32'h0, 1'b0, 32'h3E8);
        xfer("rd STATUS rst2", 1'b0, 6'h24, 32'h0, 1'b0, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
